// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the byte-addressed data memory.
// Size codes, FSM states, byte-enable generation and load extension live here.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RD_PIPE,
        RSP
    } state_t;

    function automatic logic [3:0] be_from_size(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << addr_lo;
            SZ_H:    be = 4'b0011 << addr_lo;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the low-order store data across every lane it could land on.
    function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [1:0] size);
        logic [31:0] lanes;
        case (size)
            SZ_B:    lanes = {4{wdata[7:0]}};
            SZ_H:    lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] addr_lo, input logic uns);
        logic [31:0] s;
        logic [31:0] r;
        s = word >> {addr_lo, 3'b000};
        case (size)
            SZ_B:    r = uns ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            SZ_H:    r = uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Four byte-lane RAMs sharing one word index: per-lane write enables, a
// synchronous read port and an asynchronous debug read port.
module dmem_byte_array #(
    parameter int unsigned IDX_W = 14
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic [3:0]       we,
    input  logic [31:0]      wdata,
    input  logic             re,
    output logic [31:0]      rdata,
    input  logic [IDX_W-1:0] dbg_addr,
    output logic [31:0]      dbg_rdata
);

    localparam int unsigned WORDS = 1 << IDX_W;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [WORDS];
        logic [7:0] rd_q;

        // The read register only updates on a load, so it holds the word while the response waits.
        always_ff @(posedge clk) begin
            if (we[l]) mem[addr] <= wdata[8*l +: 8];
            if (re)    rd_q      <= mem[addr];
        end

        assign rdata[8*l +: 8]     = rd_q;
        assign dbg_rdata[8*l +: 8] = mem[dbg_addr];
    end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with valid/ready request/response handshake,
// fault flagging, sign/zero-extended loads and a combinational debug peek port.
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH_B   = 65536,
    parameter int unsigned READ_LAT  = 1,
    parameter logic [31:0] ERR_RDATA = 32'h0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_uns,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_rdata
);

    localparam int unsigned IDX_W = $clog2(DEPTH_B) - 2;

    state_t           state;
    logic             accept;
    logic             fault;
    logic             out_of_range;
    logic             misaligned;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic             re;
    logic [31:0]      ram_rdata;

    logic             ld_q;
    logic [1:0]       size_q;
    logic [1:0]       lo_q;
    logic             uns_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    assign req_ready = (state == IDLE) && !RST;
    assign accept    = req_valid && req_ready;

    always_comb begin
        out_of_range = 64'(req_addr) >= 64'(DEPTH_B);
        misaligned   = 1'b0;
        if (req_size == SZ_H) misaligned = req_addr[0];
        if (req_size == SZ_W) misaligned = |req_addr[1:0];
        fault = out_of_range || misaligned || (req_size == 2'b11);
    end

    // A faulted request never reaches the array, so its index is parked at zero.
    assign idx = fault ? '0 : req_addr[IDX_W+1:2];
    assign be  = (accept && req_we && !fault) ? be_from_size(req_size, req_addr[1:0]) : 4'b0000;
    assign re  = accept && !req_we && !fault;

    dmem_byte_array #(
        .IDX_W(IDX_W)
    ) u_array (
        .clk      (CLK),
        .addr     (idx),
        .we       (be),
        .wdata    (store_lanes(req_wdata, req_size)),
        .re       (re),
        .rdata    (ram_rdata),
        .dbg_addr (dbg_addr[IDX_W+1:2]),
        .dbg_rdata(dbg_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            ld_q    <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ld_q    <= !req_we && !fault;
                        size_q  <= req_size;
                        lo_q    <= req_addr[1:0];
                        uns_q   <= req_uns;
                        err_q   <= fault;
                        rdata_q <= fault ? ERR_RDATA : 32'h0;
                        state   <= (!req_we && !fault && READ_LAT == 2) ? RD_PIPE : RSP;
                    end
                end
                RD_PIPE: state <= RSP;
                RSP:     if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Load data comes straight from the held array read register; everything else is registered.
    assign rsp_valid = (state == RSP);
    assign rsp_err   = err_q;
    assign rsp_rdata = ld_q ? load_extend(ram_rdata, size_q, lo_q, uns_q) : rdata_q;

    logic unused_bits;
    assign unused_bits = ^dbg_addr;

endmodule

// File: tb/tb_data_memory_sized.sv
// Drives two instances (READ_LAT 1 and 2) with identical stimulus and checks
// them against a byte-level reference model of the memory.
module tb_data_memory_sized;

    localparam int unsigned DEPTH = 65536;
    localparam logic [31:0] ERR   = 32'hE770_0BAD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_uns = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_ready = 1'b1;
    logic [31:0] dbg_addr = 32'h0;

    logic        ready1, ready2, rv1, rv2, err1, err2;
    logic [31:0] rd1, rd2, dbg1, dbg2;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [DEPTH];

    always #5 clk = ~clk;

    data_memory_sized #(
        .ADDR_W(32), .DEPTH_B(DEPTH), .READ_LAT(1), .ERR_RDATA(ERR)
    ) u_dut1 (
        .CLK(clk), .RST(rst), .req_valid(req_valid), .req_ready(ready1), .req_we(req_we),
        .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(err1),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg1)
    );

    data_memory_sized #(
        .ADDR_W(32), .DEPTH_B(DEPTH), .READ_LAT(2), .ERR_RDATA(ERR)
    ) u_dut2 (
        .CLK(clk), .RST(rst), .req_valid(req_valid), .req_ready(ready2), .req_we(req_we),
        .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_rdata(rd2), .rsp_err(err2),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg2)
    );

    // Reference: a flat byte array; loads gather n bytes and extend arithmetically.
    function automatic void ref_access(input logic we, input logic [1:0] size, input logic uns,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic err, output logic [31:0] rdata);
        int n;
        int bits;
        longint unsigned v;
        n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        bits  = 8 * n;
        err   = (size == 2'd3) || (addr >= DEPTH) || ((addr % n) != 0);
        rdata = 32'h0;
        if (err) begin
            rdata = ERR;
        end else if (we) begin
            for (int i = 0; i < n; i++) mem_m[addr + i] = wdata[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v + (64'(mem_m[addr + i]) << (8 * i));
            if (!uns && v[bits-1]) v = v | ~((64'd1 << bits) - 1);
            rdata = v[31:0];
        end
    endfunction

    function automatic logic [31:0] mword(input logic [31:0] addr);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        return {mem_m[a + 3], mem_m[a + 2], mem_m[a + 1], mem_m[a]};
    endfunction

    task automatic do_txn(input string name, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          lat1, lat2, exp_lat2;
        ref_access(we, size, uns, addr, wdata, exp_err, exp_rd);
        exp_lat2 = (!we && !exp_err) ? 2 : 1;
        @(negedge clk);
        checks++;
        if (ready1 !== 1'b1 || ready2 !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready got %b/%b want 1/1", name, ready1, ready2);
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat1 = 0;
        lat2 = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (lat1 == 0 && rv1) begin
                lat1 = c;
                checks++;
                if (rd1 !== exp_rd || err1 !== exp_err) begin
                    errors++;
                    $display("FAIL %s lat1 rsp got %h/%b want %h/%b", name, rd1, err1, exp_rd, exp_err);
                end
            end
            if (lat2 == 0 && rv2) begin
                lat2 = c;
                checks++;
                if (rd2 !== exp_rd || err2 !== exp_err) begin
                    errors++;
                    $display("FAIL %s lat2 rsp got %h/%b want %h/%b", name, rd2, err2, exp_rd, exp_err);
                end
            end
            if (lat1 != 0 && lat2 != 0) break;
        end
        checks++;
        if (lat1 != 1 || lat2 != exp_lat2) begin
            errors++;
            $display("FAIL %s latency got %0d/%0d want 1/%0d", name, lat1, lat2, exp_lat2);
        end
    endtask

    task automatic check_dbg(input string name, input logic [31:0] addr);
        dbg_addr = addr;
        #1;
        checks++;
        if (dbg1 !== mword(addr) || dbg2 !== mword(addr)) begin
            errors++;
            $display("FAIL %s dbg got %h/%h want %h", name, dbg1, dbg2, mword(addr));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rv1 !== 1'b0 || rv2 !== 1'b0 || rd1 !== 32'h0 || rd2 !== 32'h0 ||
            err1 !== 1'b0 || err2 !== 1'b0 || ready1 !== 1'b0 || ready2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v%b%b d%h/%h e%b%b r%b%b want all zero",
                     rv1, rv2, rd1, rd2, err1, err2, ready1, ready2);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready1 !== 1'b1 || ready2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release req_ready got %b/%b want 1/1", ready1, ready2);
        end
    endtask

    task automatic test_directed();
        do_txn("sw_200c", 1'b1, 2'd2, 1'b0, 32'h200C, 32'hDEAD_BEEF);
        do_txn("lw_200c", 1'b0, 2'd2, 1'b0, 32'h200C, 32'h0);
        check_dbg("dbg_200c", 32'h200C);
        checks++;
        if (dbg1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL dbg_const got %h want deadbeef", dbg1);
        end
        do_txn("sw_2000_0", 1'b1, 2'd2, 1'b0, 32'h2000, 32'h0);
        do_txn("sb_2001", 1'b1, 2'd0, 1'b0, 32'h2001, 32'hABCD_EF80);
        do_txn("lb_2001", 1'b0, 2'd0, 1'b0, 32'h2001, 32'h0);
        do_txn("lbu_2001", 1'b0, 2'd0, 1'b1, 32'h2001, 32'h0);
        do_txn("lw_2000_a", 1'b0, 2'd2, 1'b0, 32'h2000, 32'h0);
        do_txn("sw_2000_f", 1'b1, 2'd2, 1'b0, 32'h2000, 32'hFFFF_FFFF);
        do_txn("sh_2002", 1'b1, 2'd1, 1'b0, 32'h2002, 32'h5555_1234);
        do_txn("lw_2000_b", 1'b0, 2'd2, 1'b0, 32'h2000, 32'h0);
        do_txn("lh_2003", 1'b0, 2'd1, 1'b0, 32'h2003, 32'h0);
        do_txn("sh_2003", 1'b1, 2'd1, 1'b0, 32'h2003, 32'h0000_0000);
        do_txn("sw_2002", 1'b1, 2'd2, 1'b0, 32'h2002, 32'h0000_0000);
        do_txn("lw_2000_c", 1'b0, 2'd2, 1'b0, 32'h2000, 32'h0);
        checks++;
        if (mword(32'h2000) !== 32'h1234_FFFF) begin
            errors++;
            $display("FAIL model_2000 got %h want 1234ffff", mword(32'h2000));
        end
        do_txn("lw_depth", 1'b0, 2'd2, 1'b0, DEPTH, 32'h0);
        do_txn("sw_depth", 1'b1, 2'd2, 1'b0, DEPTH, 32'h1111_1111);
        do_txn("ld_sz3", 1'b0, 2'd3, 1'b0, 32'h2000, 32'h0);
        do_txn("st_sz3", 1'b1, 2'd3, 1'b0, 32'h2000, 32'h2222_2222);
        do_txn("lw_2000_d", 1'b0, 2'd2, 1'b0, 32'h2000, 32'h0);
        dbg_addr = 32'h2008;
        do_txn("sw_2008", 1'b1, 2'd2, 1'b0, 32'h2008, 32'hCAFE_F00D);
        check_dbg("dbg_2008", 32'h2008);
        do_txn("sw_top", 1'b1, 2'd2, 1'b0, DEPTH - 4, 32'h0BAD_F00D);
        do_txn("lw_top", 1'b0, 2'd2, 1'b0, DEPTH - 4, 32'h0);
        do_txn("lhu_top", 1'b0, 2'd1, 1'b1, DEPTH - 2, 32'h0);
        check_dbg("dbg_top", DEPTH - 4);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  sz;
        int          kind;
        for (int i = 0; i < 64; i++) do_txn("init", 1'b1, 2'd2, 1'b0, 32'h2000 + 4 * i, $urandom);
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 7);
            a    = 32'h2000 + $urandom_range(0, 255);
            sz   = 2'($urandom_range(0, 2));
            if (kind == 0) a = DEPTH + $urandom_range(0, 32'h00FF_FFFF);
            if (kind == 1) sz = 2'd3;
            do_txn("rand", 1'($urandom), sz, 1'($urandom), a, $urandom);
            check_dbg("rand_dbg", 32'h2000 + 4 * $urandom_range(0, 63));
        end
    endtask

    task automatic test_backpressure();
        logic        exp_err;
        logic [31:0] exp_rd;
        ref_access(1'b0, 2'd1, 1'b0, 32'h2006, 32'h0, exp_err, exp_rd);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd1; req_uns = 1'b0; req_addr = 32'h2006;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            checks++;
            if (rv1 !== 1'b1 || rv2 !== (c >= 2) || ready1 !== 1'b0 || ready2 !== 1'b0 ||
                rd1 !== exp_rd || err1 !== 1'b0 || (c >= 2 && (rd2 !== exp_rd || err2 !== 1'b0))) begin
                errors++;
                $display("FAIL bp_hold c%0d got v%b%b r%b%b d%h/%h want v1%b r00 d%h",
                         c, rv1, rv2, ready1, ready2, rd1, rd2, (c >= 2), exp_rd);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready1 !== 1'b1 || ready2 !== 1'b1 || rv1 !== 1'b0 || rv2 !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got r%b%b v%b%b want r11 v00", ready1, ready2, rv1, rv2);
        end
    endtask

    task automatic test_reset_inflight();
        do_txn("sw_2040", 1'b1, 2'd2, 1'b0, 32'h2040, 32'h1357_9BDF);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h2040; req_wdata = 32'h0;
        #1;
        checks++;
        if (ready1 !== 1'b0 || ready2 !== 1'b0) begin
            errors++;
            $display("FAIL rst_store_ready got %b/%b want 0/0", ready1, ready2);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rv1 !== 1'b0 || rv2 !== 1'b0 || ready1 !== 1'b1 || ready2 !== 1'b1) begin
            errors++;
            $display("FAIL rst_store_after got v%b%b r%b%b want v00 r11", rv1, rv2, ready1, ready2);
        end
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h2040;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rv2 !== 1'b0) begin
            errors++;
            $display("FAIL rd_pipe_state got rsp_valid %b want 0", rv2);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rv1 !== 1'b0 || rv2 !== 1'b0 || ready1 !== 1'b1 || ready2 !== 1'b1 ||
            rd1 !== 32'h0 || rd2 !== 32'h0 || err1 !== 1'b0 || err2 !== 1'b0) begin
            errors++;
            $display("FAIL rst_pipe_after got v%b%b r%b%b d%h/%h want v00 r11 d0",
                     rv1, rv2, ready1, ready2, rd1, rd2);
        end
        do_txn("lw_2040_kept", 1'b0, 2'd2, 1'b0, 32'h2040, 32'h0);
        check_dbg("dbg_2040_kept", 32'h2040);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
